// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The MULT/DIV unit has two states; latencies and counter widths are defaulted here.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF  = 32;
  localparam int STALL_CNT_W_DEF  = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Sequencer for the multi-cycle HI/LO unit: loads the op latency on start,
// counts down while busy and pulses md_done on the final busy cycle.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done,
  output logic md_run
);

  localparam int CNT_W = $clog2(max_int(MULT_LATENCY, DIV_LATENCY) + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY - 1);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      md_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    case (state_reg)
      RUN: begin
        if (start) begin
          md_cnt_next = is_div ? DIV_LOAD : MULT_LOAD;
          state_next  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A start seen here belongs to nobody: the unit only accepts ops in RUN.
        if (md_cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          md_cnt_next = md_cnt_reg - 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Outputs are masked during reset so an aborted op never reports done.
  assign md_busy = (state_reg == MD_BUSY) && !reset;
  assign md_done = md_busy && (md_cnt_reg == '0);
  assign md_run  = (state_reg == RUN);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use and HI/LO hazard detection, PC/IF_ID enables,
// IF_ID/ID_EX flushes and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
  parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             ID_rs,
  input  logic [4:0]             ID_rt,
  input  logic                   ID_uses_rt,
  input  logic                   ID_md_op,
  input  logic                   ID_is_mfhilo,
  input  logic                   ID_jump,
  input  logic                   ID_EX_MemRead,
  input  logic [4:0]             ID_EX_rt,
  input  logic                   EX_md_start,
  input  logic                   EX_md_is_div,
  input  logic                   EX_branch_taken,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic md_run;
  logic load_use;
  logic md_hold;
  logic stall;
  logic stall_applied;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  // The md op in EX is older than any branch resolving alongside it, so it starts regardless.
  md_busy_timer #(
    .MULT_LATENCY (MULT_LATENCY),
    .DIV_LATENCY  (DIV_LATENCY)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (EX_md_start),
    .is_div  (EX_md_is_div),
    .md_busy (md_busy),
    .md_done (md_done),
    .md_run  (md_run)
  );

  assign load_use = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) &&
                    ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));

  // On the done cycle HI/LO is valid next cycle, so a dependent op may advance.
  assign md_hold = (ID_md_op || ID_is_mfhilo) &&
                   ((md_busy && !md_done) || (md_run && EX_md_start));

  assign stall = load_use || md_hold;

  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    stall_applied = 1'b0;
    if (!reset) begin
      if (EX_branch_taken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (stall) begin
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Flush   = 1'b1;
        stall_applied = 1'b1;
      end else if (ID_jump) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_applied && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 4-bit
// stall counter exercises saturation.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, ID_EX_rt;
  logic        ID_uses_rt, ID_md_op, ID_is_mfhilo, ID_jump;
  logic        ID_EX_MemRead, EX_md_start, EX_md_is_div, EX_branch_taken;

  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_busy, md_done;
  logic [31:0] stall_cycles;
  logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Flush, s_md_busy, s_md_done;
  logic [3:0]  s_stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_md_op(ID_md_op), .ID_is_mfhilo(ID_is_mfhilo), .ID_jump(ID_jump),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .EX_md_start(EX_md_start),
    .EX_md_is_div(EX_md_is_div), .EX_branch_taken(EX_branch_taken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_md_op(ID_md_op), .ID_is_mfhilo(ID_is_mfhilo), .ID_jump(ID_jump),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .EX_md_start(EX_md_start),
    .EX_md_is_div(EX_md_is_div), .EX_branch_taken(EX_branch_taken),
    .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush),
    .ID_EX_Flush(s_ID_EX_Flush), .md_busy(s_md_busy), .md_done(s_md_done),
    .stall_cycles(s_stall_cycles)
  );

  task automatic clear_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_EX_rt = 5'd0;
    ID_uses_rt = 1'b0; ID_md_op = 1'b0; ID_is_mfhilo = 1'b0; ID_jump = 1'b0;
    ID_EX_MemRead = 1'b0; EX_md_start = 1'b0; EX_md_is_div = 1'b0; EX_branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Outputs during reset must be defaults even with a load-use hazard present.
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd3; ID_rs = 5'd3;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_busy, md_done} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=110000",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, md_busy, md_done});
    end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt got=%0d want=0", stall_cycles);
    end
    $display("test_reset: outputs=%b stall_cycles=%0d",
             {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}, stall_cycles);
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; ID_rs = 5'd8;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin
      failures++;
      $display("FAIL load_use_rs got=%b want=0001", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    end
    next_cycle();
    ID_EX_rt = 5'd0; ID_rs = 5'd0;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin
      failures++;
      $display("FAIL load_use_r0 got=%b want=1100", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL load_use_count got=%0d want=1", stall_cycles);
    end
    next_cycle();
    ID_EX_rt = 5'd9; ID_rt = 5'd9; ID_rs = 5'd1; ID_uses_rt = 1'b0;
    @(negedge clk);
    checks++;
    if (PC_Write !== 1'b1) begin
      failures++;
      $display("FAIL load_use_rt_unused got=%b want=1", PC_Write);
    end
    ID_uses_rt = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, ID_EX_Flush} !== 2'b01) begin
      failures++;
      $display("FAIL load_use_rt_used got=%b want=01", {PC_Write, ID_EX_Flush});
    end
    $display("test_load_use: stall_cycles=%0d", stall_cycles);
    clear_inputs();
  endtask

  task automatic test_md_div();
    do_reset();
    EX_md_start = 1'b1; EX_md_is_div = 1'b1; ID_is_mfhilo = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, ID_EX_Flush, md_busy} !== 3'b010) begin
      failures++;
      $display("FAIL div_start_cycle got=%b want=010", {PC_Write, ID_EX_Flush, md_busy});
    end
    next_cycle();
    EX_md_start = 1'b0; EX_md_is_div = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      logic last;
      last = (i == 32);
      @(negedge clk);
      checks++;
      if ({md_busy, md_done, PC_Write} !== {1'b1, last, last}) begin
        failures++;
        $display("FAIL div_busy_cycle%0d got=%b want=%b", i, {md_busy, md_done, PC_Write},
                 {1'b1, last, last});
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if ({md_busy, md_done, PC_Write} !== 3'b001) begin
      failures++;
      $display("FAIL div_after got=%b want=001", {md_busy, md_done, PC_Write});
    end
    checks++;
    if (stall_cycles !== 32'd32) begin
      failures++;
      $display("FAIL div_stall_count got=%0d want=32", stall_cycles);
    end
    $display("test_md_div: stall_cycles=%0d", stall_cycles);
    clear_inputs();
  endtask

  // MULT runs 4 cycles; a DIV start arriving mid-op must be ignored.
  task automatic test_md_mult_ignore_start();
    do_reset();
    EX_md_start = 1'b1;
    next_cycle();
    EX_md_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic last;
      last = (i == 4);
      if (i == 2) begin
        EX_md_start = 1'b1; EX_md_is_div = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({md_busy, md_done} !== {1'b1, last}) begin
        failures++;
        $display("FAIL mult_cycle%0d got=%b want=%b", i, {md_busy, md_done}, {1'b1, last});
      end
      next_cycle();
      EX_md_start = 1'b0; EX_md_is_div = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL mult_ignore_start got=%b want=0", md_busy);
    end
    $display("test_md_mult_ignore_start: md_busy=%b", md_busy);
  endtask

  task automatic test_branch();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd4; ID_rs = 5'd4; EX_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1111) begin
      failures++;
      $display("FAIL branch_over_stall got=%b want=1111",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    end
    clear_inputs();
    EX_branch_taken = 1'b1; EX_md_start = 1'b1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL branch_no_count got=%0d want=0", stall_cycles);
    end
    checks++;
    if (md_busy !== 1'b1) begin
      failures++;
      $display("FAIL branch_md_start got=%b want=1", md_busy);
    end
    $display("test_branch: stall_cycles=%0d md_busy=%b", stall_cycles, md_busy);
  endtask

  task automatic test_reset_mid_op();
    int done_pulses;
    do_reset();
    done_pulses = 0;
    EX_md_start = 1'b1; EX_md_is_div = 1'b1; ID_md_op = 1'b1;
    next_cycle();
    EX_md_start = 1'b0;
    for (int i = 1; i < 10; i++) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({md_busy, PC_Write} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_during got=%b want=01", {md_busy, PC_Write});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({md_busy, stall_cycles} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_mid_after busy=%b cnt=%0d want busy=0 cnt=0", md_busy, stall_cycles);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (md_done === 1'b1) done_pulses++;
    end
    checks++;
    if (done_pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d pulses want=0", done_pulses);
    end
    $display("test_reset_mid_op: md_done pulses=%0d", done_pulses);
    clear_inputs();
  endtask

  task automatic test_jump();
    do_reset();
    ID_jump = 1'b1;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1110) begin
      failures++;
      $display("FAIL jump_alone got=%b want=1110", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    end
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd12; ID_rs = 5'd12;
    @(negedge clk);
    checks++;
    if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin
      failures++;
      $display("FAIL jump_with_stall got=%b want=0001",
               {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    end
    $display("test_jump: outputs=%b", {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd7; ID_rs = 5'd7;
    for (int i = 0; i < 20; i++) next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (s_stall_cycles !== 4'd15) begin
      failures++;
      $display("FAIL sat_4bit got=%0d want=15", s_stall_cycles);
    end
    checks++;
    if (stall_cycles !== 32'd20) begin
      failures++;
      $display("FAIL sat_32bit got=%0d want=20", stall_cycles);
    end
    $display("test_saturation: narrow=%0d wide=%0d", s_stall_cycles, stall_cycles);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_md_div();
    test_md_mult_ignore_start();
    test_branch();
    test_reset_mid_op();
    test_jump();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
